// File: rtl/pad_cond_pkg.sv
// Shared constants for the pad input conditioner.
//   DEF_WIDTH   : default number of pad channels
//   DEF_CNT_W   : default debounce counter width
//   SYNC_STAGES : flops in each input synchroniser chain
package pad_cond_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pad_cond_bit.sv
// One pad channel: synchroniser, debounce counter, stable level,
// edge pulses and sticky interrupt status bit.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   pad_i          raw pad level (asynchronous)
//   db_limit_i     debounce threshold (quasi-static)
//   rise_en_i      rising-edge interrupt enable
//   fall_en_i      falling-edge interrupt enable
//   clr_i          write-1-to-clear for the status bit
//   data_o         debounced level
//   rise_o/fall_o  one-cycle pulses on debounced transitions
//   status_o       sticky edge-event flag
module pad_cond_bit
    import pad_cond_pkg::*;
#(
    parameter int   CNT_W   = DEF_CNT_W,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_i,
    input  logic [CNT_W-1:0] db_limit_i,
    input  logic             rise_en_i,
    input  logic             fall_en_i,
    input  logic             clr_i,
    output logic             data_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             status_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pure shift chain: nothing between the stages so metastability has
    // a full cycle to resolve before the level is used.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s2;

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stb_q,    stb_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             status_q, status_d;

    assign s2 = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        stb_d  = stb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2 == stb_q) begin
            cnt_d = '0;
        end else if (cnt_q >= db_limit_i) begin
            // >= rather than == so that lowering the threshold below a
            // running count accepts at once and the counter never wraps.
            stb_d  = s2;
            cnt_d  = '0;
            rise_d = s2;
            fall_d = ~s2;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        // A new event outranks a clear arriving in the same cycle.
        status_d = (status_q & ~clr_i) | (rise_q & rise_en_i) | (fall_q & fall_en_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            cnt_q    <= '0;
            stb_q    <= RST_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pad_i};
            cnt_q    <= cnt_d;
            stb_q    <= stb_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
        end
    end

    assign data_o   = stb_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign status_o = status_q;

endmodule

// File: rtl/pad_in_conditioner.sv
// Multi-channel pad input conditioner: per-bit synchronise + debounce +
// edge detect + sticky interrupt status, with a combined interrupt line.
// Ports:
//   CLK, RESET     clock, asynchronous active-high reset
//   PAD_I          raw pad receiver outputs
//   DB_LIMIT       debounce threshold
//   IRQ_RISE_EN    per-bit rising-edge interrupt enables
//   IRQ_FALL_EN    per-bit falling-edge interrupt enables
//   IRQ_CLR        per-bit write-1-to-clear for IRQ_STATUS
//   DATA_O         debounced levels
//   RISE_O/FALL_O  one-cycle debounced edge pulses
//   IRQ_STATUS     sticky edge-event flags
//   IRQ            OR of IRQ_STATUS
module pad_in_conditioner
    import pad_cond_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PAD_I,
    input  logic [CNT_W-1:0] DB_LIMIT,
    input  logic [WIDTH-1:0] IRQ_RISE_EN,
    input  logic [WIDTH-1:0] IRQ_FALL_EN,
    input  logic [WIDTH-1:0] IRQ_CLR,
    output logic [WIDTH-1:0] DATA_O,
    output logic [WIDTH-1:0] RISE_O,
    output logic [WIDTH-1:0] FALL_O,
    output logic [WIDTH-1:0] IRQ_STATUS,
    output logic             IRQ
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            pad_cond_bit #(
                .CNT_W  (CNT_W),
                .RST_VAL(RESET_VAL[gi])
            ) u_bit (
                .clk_i     (CLK),
                .rst_i     (RESET),
                .pad_i     (PAD_I[gi]),
                .db_limit_i(DB_LIMIT),
                .rise_en_i (IRQ_RISE_EN[gi]),
                .fall_en_i (IRQ_FALL_EN[gi]),
                .clr_i     (IRQ_CLR[gi]),
                .data_o    (DATA_O[gi]),
                .rise_o    (RISE_O[gi]),
                .fall_o    (FALL_O[gi]),
                .status_o  (IRQ_STATUS[gi])
            );
        end
    endgenerate

    assign IRQ = |IRQ_STATUS;

endmodule

// File: tb/tb_pad_in_conditioner.sv
module tb_pad_in_conditioner;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [W-1:0]  PAD_I;
    logic [CW-1:0] DB_LIMIT;
    logic [W-1:0]  IRQ_RISE_EN, IRQ_FALL_EN, IRQ_CLR;
    logic [W-1:0]  DATA_O, RISE_O, FALL_O, IRQ_STATUS;
    logic          IRQ;

    pad_in_conditioner #(.WIDTH(W), .CNT_W(CW), .RESET_VAL({W{1'b0}})) dut (
        .CLK(CLK), .RESET(RESET), .PAD_I(PAD_I), .DB_LIMIT(DB_LIMIT),
        .IRQ_RISE_EN(IRQ_RISE_EN), .IRQ_FALL_EN(IRQ_FALL_EN), .IRQ_CLR(IRQ_CLR),
        .DATA_O(DATA_O), .RISE_O(RISE_O), .FALL_O(FALL_O),
        .IRQ_STATUS(IRQ_STATUS), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] stat;
        logic         irq;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the debounced level follows the pad as seen two
    // samples late, once that view has disagreed with it for DB_LIMIT+1
    // consecutive cycles. Events flag the cycle the new level appears;
    // status latches enabled events one cycle later.
    logic [W-1:0] seen [0:1];   // pad as sampled 1 and 2 edges ago
    logic [W-1:0] m_lvl, m_rise, m_fall, m_stat;
    int           m_disagree [W];

    task automatic model_reset();
        seen[0] = '0; seen[1] = '0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_stat = '0;
        for (int i = 0; i < W; i++) m_disagree[i] = 0;
    endtask

    task automatic model_step();
        exp_t e;
        logic [W-1:0] nr, nf;
        if (RESET) begin
            model_reset();
        end else begin
            m_stat = (m_stat & ~IRQ_CLR) | (m_rise & IRQ_RISE_EN) | (m_fall & IRQ_FALL_EN);
            nr = '0; nf = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[1][i] != m_lvl[i]) begin
                    m_disagree[i] = m_disagree[i] + 1;
                    if (m_disagree[i] >= int'(DB_LIMIT) + 1) begin
                        m_lvl[i] = seen[1][i];
                        if (m_lvl[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
                        m_disagree[i] = 0;
                    end
                end else begin
                    m_disagree[i] = 0;
                end
            end
            m_rise = nr; m_fall = nf;
            seen[1] = seen[0];
            seen[0] = PAD_I;
        end
        e.data = m_lvl; e.rise = m_rise; e.fall = m_fall;
        e.stat = m_stat; e.irq = |m_stat;
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            model_step();
        end
    end

    // Monitor: one output sample per clock, compared against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (DATA_O !== e.data || RISE_O !== e.rise || FALL_O !== e.fall ||
                    IRQ_STATUS !== e.stat || IRQ !== e.irq) begin
                    n_bad++;
                    $display("FAIL outputs at %0t: got data=%h rise=%h fall=%h stat=%h irq=%b want data=%h rise=%h fall=%h stat=%h irq=%b",
                             $time, DATA_O, RISE_O, FALL_O, IRQ_STATUS, IRQ,
                             e.data, e.rise, e.fall, e.stat, e.irq);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Counts edges from the current point until the selected output bit
    // goes high (sel 0: DATA_O, 1: FALL_O), bounded.
    task automatic latency(input string name, input int sel, input int b, input int exp_n);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
            hit = (sel == 0) ? DATA_O[b] : FALL_O[b];
        end
        check(name, hit ? n : -1, exp_n);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; PAD_I = '0; DB_LIMIT = 16'd4;
        IRQ_RISE_EN = '0; IRQ_FALL_EN = '0; IRQ_CLR = '0;
        cyc(3);
        check("reset_data", int'(DATA_O), 0);
        check("reset_irq", int'({IRQ, IRQ_STATUS}), 0);
        RESET = 1'b0;
        cyc(3);

        // Held rising edge with DB_LIMIT=4: 7 edges, no status with enables off.
        PAD_I[0] = 1'b1;
        latency("lat_db4", 0, 0, 7);
        cyc(3);
        check("no_status_disabled", int'(IRQ_STATUS), 0);

        // Short glitch is filtered.
        PAD_I[1] = 1'b1;
        cyc(3);
        PAD_I[1] = 1'b0;
        cyc(12);
        check("glitch_filtered", int'(DATA_O[1]), 0);

        // DB_LIMIT=0 falling edge with interrupt, then clear.
        DB_LIMIT = 16'd0; IRQ_FALL_EN = 8'h04; PAD_I[2] = 1'b1;
        cyc(6);
        PAD_I[2] = 1'b0;
        latency("lat_db0_fall", 1, 2, 3);
        cyc(2);
        check("irq_set", int'({IRQ, IRQ_STATUS}), 9'h104);
        IRQ_CLR = 8'h04;
        cyc(1);
        IRQ_CLR = 8'h00;
        cyc(1);
        check("irq_cleared", int'(IRQ), 0);

        // Clear coinciding with a new enabled edge: set wins.
        IRQ_RISE_EN = 8'h08; PAD_I[3] = 1'b1;
        cyc(3);
        IRQ_CLR = 8'h08;
        cyc(1);
        IRQ_CLR = 8'h00;
        check("set_beats_clr", int'(IRQ_STATUS[3]), 1);
        IRQ_RISE_EN = 8'h00;
        cyc(3);
        check("disable_keeps_status", int'(IRQ_STATUS[3]), 1);

        // Reset mid-debounce discards the count.
        PAD_I = '0; DB_LIMIT = 16'd100;
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
        cyc(2);
        PAD_I[0] = 1'b1;
        cyc(52);
        RESET = 1'b1;
        #1;
        check("async_reset_outputs", int'({IRQ, IRQ_STATUS, DATA_O, RISE_O, FALL_O}), 0);
        cyc(2);
        RESET = 1'b0;
        latency("lat_after_reset", 0, 0, 103);

        // Lowering DB_LIMIT below the running count accepts on the next edge.
        @(negedge CLK);
        DB_LIMIT = 16'd20; PAD_I[1] = 1'b1;
        cyc(12);
        check("before_limit_drop", int'(DATA_O[1]), 0);
        DB_LIMIT = 16'd2;
        @(posedge CLK);
        #1;
        check("after_limit_drop", int'(DATA_O[1]), 1);

        // Randomised traffic.
        @(negedge CLK);
        DB_LIMIT = 16'($urandom_range(0, 4));
        for (int c = 0; c < 800; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 199) == 0) RESET = 1'b1;
            else RESET = 1'b0;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 3) == 0) PAD_I[i] = ~PAD_I[i];
            if ($urandom_range(0, 49) == 0) DB_LIMIT = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) begin
                IRQ_RISE_EN = 8'($urandom);
                IRQ_FALL_EN = 8'($urandom);
            end
            IRQ_CLR = 8'($urandom) & 8'($urandom) & 8'($urandom);
        end
        @(negedge CLK);
        RESET = 1'b0; IRQ_CLR = '0;
        cyc(10);
        @(posedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pad_in_conditioner.md
PAD_IN_CONDITIONER -- requirements
Module: pad_in_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of pad input channels.
REQ-002 SHALL have parameter CNT_W, default 16: debounce counter width.
REQ-003 SHALL have parameter RESET_VAL, default {WIDTH{1'b0}}: reset level of synchronizer and debounced state.
REQ-004 Ports SHALL be:
  CLK  input  1  single clock.
  RESET  input  1  asynchronous, active-high reset.
  PAD_I  input  WIDTH  raw pad receiver outputs (IOBUF O), asynchronous to CLK.
  DB_LIMIT  input  CNT_W  debounce threshold, quasi-static.
  IRQ_RISE_EN  input  WIDTH  per-bit rising-edge interrupt enable.
  IRQ_FALL_EN  input  WIDTH  per-bit falling-edge interrupt enable.
  IRQ_CLR  input  WIDTH  per-bit write-1-to-clear pulse for IRQ_STATUS.
  DATA_O  output  WIDTH  debounced pad level.
  RISE_O  output  WIDTH  one-cycle pulse on a debounced 0->1 transition.
  FALL_O  output  WIDTH  one-cycle pulse on a debounced 1->0 transition.
  IRQ_STATUS  output  WIDTH  sticky edge-event flags.
  IRQ  output  1  OR-reduction of IRQ_STATUS.

Function
REQ-005 Each bit SHALL pass PAD_I through a two-flop synchroniser (s1, s2); no logic between s1 and s2.
REQ-006 Each bit SHALL hold a CNT_W-bit counter cnt and a stable register stb driving DATA_O.
REQ-007 Per-cycle update: s2 == stb -> cnt <= 0; s2 != stb and cnt >= DB_LIMIT -> stb <= s2, cnt <= 0; otherwise cnt <= cnt + 1.
REQ-008 A new level SHALL therefore reach DATA_O only after s2 differs from stb for DB_LIMIT+1 consecutive cycles; total latency from a PAD_I change (setup met) to DATA_O = DB_LIMIT+3 CLK edges.
REQ-009 DB_LIMIT = 0 SHALL give pure synchronisation: latency 3 edges, any glitch held >= 1 cycle in s2 propagates.
REQ-010 A glitch returning s2 to stb before the threshold SHALL reset cnt to 0 with no DATA_O change.
REQ-011 Lowering DB_LIMIT below a running cnt SHALL cause acceptance on the next cycle (>= compare); cnt SHALL never wrap.
REQ-012 RISE_O/FALL_O SHALL be registered, asserted for exactly the first cycle DATA_O shows the new level, never both in one cycle per bit.
REQ-013 IRQ_STATUS[i] SHALL set on (RISE_O[i] & IRQ_RISE_EN[i]) | (FALL_O[i] & IRQ_FALL_EN[i]) one cycle after that pulse.
REQ-014 IRQ_CLR[i] SHALL clear IRQ_STATUS[i] on the next edge; simultaneous set and clear SHALL leave the bit set.
REQ-015 Disabling an enable SHALL NOT clear an already-set status bit.
REQ-016 IRQ SHALL be combinational OR of IRQ_STATUS, zero-latency relative to it.

Reset
REQ-017 RESET high SHALL asynchronously force s1, s2, stb to RESET_VAL; cnt, RISE_O, FALL_O, IRQ_STATUS to 0; IRQ to 0.
REQ-018 Release of RESET SHALL produce no RISE_O/FALL_O pulse when PAD_I equals RESET_VAL.
REQ-019 RESET asserted mid-debounce SHALL discard the pending count; afterwards the full DB_LIMIT+3 latency applies again.

Structure
REQ-020 A shared package pad_cond_pkg SHALL hold the default WIDTH and CNT_W constants and the synchroniser stage count (2).
REQ-021 One sub-module pad_cond_bit (sync, counter, stb, edge pulses, status bit) SHALL be instantiated WIDTH times via generate; the top SHALL hold only the IRQ reduction.

Verification
REQ-022 DB_LIMIT=4, PAD_I[0] 0->1 held -> DATA_O[0] rises exactly 7 edges later, RISE_O[0] high 1 cycle, IRQ_STATUS unchanged with enables 0.
REQ-023 DB_LIMIT=4, PAD_I[1] high for 3 cycles then low -> DATA_O[1], RISE_O[1] stay 0; cnt returns to 0.
REQ-024 DB_LIMIT=0, IRQ_FALL_EN=8'h04, PAD_I[2] 1->0 after settling high -> FALL_O[2] 3 edges after change, IRQ_STATUS=8'h04, IRQ=1 next cycle; IRQ_CLR=8'h04 -> IRQ 0.
REQ-025 IRQ_CLR[3] asserted in the same cycle a new enabled edge sets bit 3 -> IRQ_STATUS[3] remains 1.
REQ-026 DB_LIMIT=100, assert RESET at cnt=50 with PAD_I held 1, release -> DATA_O[0] rises 103 edges after release, no pulse at release.
REQ-027 DB_LIMIT=20 changed to 2 while cnt=10 -> DATA_O updates on the following edge.
